// File: rtl/btn_enc_pkg.sv
// Shared definitions for the push-button position encoder.
//   state_e         : FSM state encoding (idle, debounce, pressed, release)
//   BTN_NONE        : raw/synchronized pattern with no button pressed
//   enc_t           : result of encode_one_cold (2-bit index + one-cold flag)
//   encode_one_cold : maps a one-cold active-low pattern to its button index
package btn_enc_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_PRESSED  = 2'd2,
        S_RELEASE  = 2'd3
    } state_e;

    localparam logic [3:0] BTN_NONE = 4'b1111;

    typedef struct packed {
        logic [1:0] idx;
        logic       one_cold;
    } enc_t;

    // Exactly one low bit is a valid single press; anything else is flagged.
    function automatic enc_t encode_one_cold(input logic [3:0] pat);
        enc_t res;
        res.idx      = 2'd0;
        res.one_cold = 1'b1;
        case (pat)
            4'b1110: res.idx = 2'd0;
            4'b1101: res.idx = 2'd1;
            4'b1011: res.idx = 2'd2;
            4'b0111: res.idx = 2'd3;
            default: res.one_cold = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/btn_position_encoder_if.sv
// Button-side bus of the position encoder.
//   btn_n : raw active-low buttons (driven by the board / master)
//   index : index of the last accepted press
//   valid : one-cycle strobe on an accepted single press
//   held  : high while the accepted button stays pressed
//   multi : one-cycle strobe on a stable multi-button pattern
interface btn_position_encoder_if;
    logic [3:0] btn_n;
    logic [1:0] index;
    logic       valid;
    logic       held;
    logic       multi;

    modport master (
        output btn_n,
        input  index,
        input  valid,
        input  held,
        input  multi
    );

    modport slave (
        input  btn_n,
        output index,
        output valid,
        output held,
        output multi
    );
endinterface

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the four asynchronous active-low buttons.
//   i_clk     : clock
//   i_reset_n : synchronous active-low reset; both stages reset to "none pressed"
//   i_btn_n   : raw button pins
//   o_btn_s   : synchronized buttons
module btn_sync
    import btn_enc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [3:0] i_btn_n,
    output logic [3:0] o_btn_s
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            meta_q <= BTN_NONE;
            sync_q <= BTN_NONE;
        end else begin
            meta_q <= i_btn_n;
            sync_q <= meta_q;
        end
    end

    assign o_btn_s = sync_q;

endmodule

// File: rtl/btn_position_encoder.sv
// Debounced encoder for four active-low push-buttons. A stable one-cold pattern
// is turned into a 2-bit index with a one-cycle press strobe; stable
// multi-button patterns raise a separate strobe. A new press is only accepted
// after a fully debounced release, so roll-overs never re-trigger.
//   i_clk           : clock
//   i_reset_n       : synchronous active-low reset
//   bus (slave)     : btn_n in; index, valid, held, multi out (all registered)
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a pattern (>= 2)
//   CNT_W           : debounce counter width
module btn_position_encoder
    import btn_enc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 100_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input logic                   i_clk,
    input logic                   i_reset_n,
    btn_position_encoder_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       btn_s;
    state_e           state_q;
    logic [3:0]       pat_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       index_q;
    logic             valid_q;
    logic             held_q;
    logic             multi_q;
    enc_t             enc;

    btn_sync u_sync (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_btn_n   (bus.btn_n),
        .o_btn_s   (btn_s)
    );

    assign enc = encode_one_cold(pat_q);

    // Counter is cleared on every transition and compared before increment,
    // so it never exceeds CNT_MAX.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            pat_q   <= BTN_NONE;
            cnt_q   <= '0;
            index_q <= 2'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            multi_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (btn_s != BTN_NONE) begin
                        pat_q   <= btn_s;
                        cnt_q   <= '0;
                        state_q <= S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (btn_s != pat_q) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_q <= '0;
                        if (enc.one_cold) begin
                            index_q <= enc.idx;
                            valid_q <= 1'b1;
                            held_q  <= 1'b1;
                            state_q <= S_PRESSED;
                        end else begin
                            multi_q <= 1'b1;
                            state_q <= S_RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_PRESSED: begin
                    // Any change, including a roll to another button, forces a
                    // full debounced release before the next press.
                    if (btn_s != pat_q) begin
                        held_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (btn_s != BTN_NONE) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.index = index_q;
    assign bus.valid = valid_q;
    assign bus.held  = held_q;
    assign bus.multi = multi_q;

endmodule
